// File: rtl/ysyx_24080006_pkg.sv
// Shared types for the EX-stage multiply/divide unit and its link to the ALU adder.
package ysyx_24080006_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    localparam int MDU_ITER = 32;

    typedef struct packed {
        logic [32:0] a;
        logic [32:0] b;
    } mdu2alu_t;

    typedef struct packed {
        logic [33:0] res_34;
        logic [31:0] res_32;
        logic        not_zero;
    } alu2mdu_t;

    function automatic logic op_is_div(input mdu_op_e op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic op_is_rem(input mdu_op_e op);
        return op inside {REM, REMU};
    endfunction

    function automatic logic op_is_mulh(input mdu_op_e op);
        return op inside {MULH, MULHSU, MULHU};
    endfunction

    function automatic logic op_a_signed(input mdu_op_e op);
        return op inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic op_b_signed(input mdu_op_e op);
        return op inside {MUL, MULH, DIV, REM};
    endfunction

endpackage

// File: rtl/ysyx_24080006_mdu_neg.sv
// Combinational 64-bit conditional two's-complement negate.
module ysyx_24080006_mdu_neg (
    input  logic        enable,
    input  logic [63:0] in,
    output logic [63:0] out
);
    assign out = enable ? (~in + 64'd1) : in;
endmodule

// File: rtl/ysyx_24080006_mdu.sv
// Iterative RV32M multiply/divide unit; borrows the ALU's 33-bit adder while in CALC.
module ysyx_24080006_mdu
    import ysyx_24080006_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        mdu_enable,
    output mdu2alu_t    mdu2alu,
    input  alu2mdu_t    alu2mdu
);
    localparam int CNT_W = $clog2(MDU_ITER) + 1;

    mdu_state_e       state_q, state_d;
    mdu_op_e          op_in, op_q;
    logic [31:0]      m_q, hi_q, lo_q, hi_nxt, lo_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q, sign_a, sign_b, div_zero, accept, last_iter, ge;
    logic [32:0]      r_sh, mul_sum;
    logic [63:0]      neg_a, neg_b, fix_in, fix_out;
    logic             unused_bits;

    assign op_in     = mdu_op_e'(in_op);
    assign sign_a    = op_a_signed(op_in) & in_a[31];
    assign sign_b    = op_b_signed(op_in) & in_b[31];
    assign div_zero  = op_is_div(op_in) && (in_b == 32'd0);
    assign accept    = in_valid & in_ready & ~flush;
    assign last_iter = (cnt_q == CNT_W'(1));

    ysyx_24080006_mdu_neg u_neg_a (.enable(sign_a), .in({32'd0, in_a}), .out(neg_a));
    ysyx_24080006_mdu_neg u_neg_b (.enable(sign_b), .in({32'd0, in_b}), .out(neg_b));

    // Restoring-divide partial remainder and shift-add partial sum share the hi/lo pair.
    assign r_sh    = {hi_q, lo_q[31]};
    assign ge      = r_sh[32] | alu2mdu.res_34[33];
    assign mul_sum = alu2mdu.res_34[33:1];

    always_comb begin
        if (op_is_div(op_q)) begin
            hi_nxt = ge ? alu2mdu.res_32 : r_sh[31:0];
            lo_nxt = {lo_q[30:0], ge};
        end else begin
            hi_nxt = mul_sum[32:1];
            lo_nxt = {mul_sum[0], lo_q[31:1]};
        end
    end

    // Final sign fixup is taken from the last iteration's next values so DONE entry registers it.
    assign fix_in = op_is_div(op_q) ? {32'd0, (op_is_rem(op_q) ? hi_nxt : lo_nxt)}
                                    : {hi_nxt, lo_nxt};

    ysyx_24080006_mdu_neg u_neg_fix (.enable(neg_q), .in(fix_in), .out(fix_out));

    assign unused_bits = ^{neg_a[63:32], neg_b[63:32], alu2mdu.res_34[0], alu2mdu.not_zero};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = div_zero ? DONE : CALC;
                CALC:    if (last_iter) state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);
        mdu_enable = (state_q == CALC);
        mdu2alu    = '0;
        if (state_q == CALC) begin
            if (op_is_div(op_q)) begin
                mdu2alu.a = {r_sh[31:0], 1'b1};
                mdu2alu.b = ~{m_q, 1'b0};
            end else begin
                mdu2alu.a = {hi_q, 1'b0};
                mdu2alu.b = lo_q[0] ? {m_q, 1'b0} : 33'd0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q       <= MUL;
            m_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            out_result <= '0;
        end else if (accept) begin
            op_q  <= op_in;
            m_q   <= op_is_div(op_in) ? neg_b[31:0] : neg_a[31:0];
            lo_q  <= op_is_div(op_in) ? neg_a[31:0] : neg_b[31:0];
            hi_q  <= '0;
            cnt_q <= CNT_W'(MDU_ITER);
            neg_q <= op_is_rem(op_in) ? sign_a : (sign_a ^ sign_b);
            if (div_zero) begin
                out_result <= op_is_rem(op_in) ? in_a : 32'hFFFF_FFFF;
            end
        end else if (state_q == CALC && !flush) begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_iter) begin
                out_result <= op_is_mulh(op_q) ? fix_out[63:32] : fix_out[31:0];
            end
        end
    end

endmodule
